// File: rtl/vedic_mac_accumulator.sv
// Multiply-accumulate stage: a 2x2 vedic multiplier feeding an accumulator that
// sums NUM_TERMS products into one result, with valid/ready on both sides.

module vedic_mul_2x2 (
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic [3:0] M
);
  logic p0, s1, c1, s2, c2;

  // Vertical and crosswise partial products combined with two half adders.
  assign p0 = A[0] & B[0];
  assign s1 = (A[1] & B[0]) ^ (A[0] & B[1]);
  assign c1 = (A[1] & B[0]) & (A[0] & B[1]);
  assign s2 = (A[1] & B[1]) ^ c1;
  assign c2 = (A[1] & B[1]) & c1;
  assign M  = {c2, s2, s1, p0};
endmodule

// Handshake: a beat moves when in_valid && in_ready at a rising edge; a result
// moves when out_valid && out_ready at a rising edge. in_ready is low in DONE.
module vedic_mac_accumulator #(
  parameter  int NUM_TERMS = 4,
  parameter  int ACC_W     = 8,
  localparam int CNT_W     = $clog2(NUM_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [1:0]       A,
  input  logic [1:0]       B,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       dbg_state
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [3:0]         prod;
  logic [ACC_W:0]     sum;
  logic [CNT_W-1:0]   cnt_inc;
  logic               beat;

  vedic_mul_2x2 u_mul (
    .A (A),
    .B (B),
    .M (prod)
  );

  // Extra top bit of the sum is the carry-out that feeds the sticky flag.
  assign sum     = {1'b0, acc_q} + (ACC_W+1)'(prod);
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    in_ready  = (state_q != DONE);
    out_valid = (state_q == DONE);
    beat      = in_valid && in_ready;
    case (state_q)
      IDLE: begin
        if (beat) begin
          acc_d   = ACC_W'(prod);
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = (NUM_TERMS == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = sum[ACC_W-1:0];
          cnt_d = cnt_inc;
          ovf_d = ovf_q | sum[ACC_W];
          if (cnt_inc == CNT_W'(NUM_TERMS)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over any beat or result handshake in the same cycle.
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_out   = acc_q;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// Directed bench for vedic_mac_accumulator: default 8-bit instance plus a
// 4-bit accumulator instance sharing the same stimulus for the wrap case.
module tb_vedic_mac_accumulator;
  logic       clk;
  logic       rst;
  logic       clear;
  logic [1:0] a;
  logic [1:0] b;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready, out_valid, overflow;
  logic [7:0] acc_out;
  logic [2:0] count;
  logic [1:0] dbg_state;

  logic       in_ready4, out_valid4, overflow4;
  logic [3:0] acc_out4;
  logic [2:0] count4;
  logic [1:0] dbg_state4;

  int n_vec;
  int n_err;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  vedic_mac_accumulator u_dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .A         (a),
    .B         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .count     (count),
    .dbg_state (dbg_state)
  );

  vedic_mac_accumulator #(.NUM_TERMS(4), .ACC_W(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .A         (a),
    .B         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .acc_out   (acc_out4),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .overflow  (overflow4),
    .count     (count4),
    .dbg_state (dbg_state4)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge; returns at the following falling edge, where outputs are
  // sampled and inputs are changed.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] av, input logic [1:0] bv);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    clear     = 1'b0;
    a         = 2'd3;
    b         = 2'd3;
    in_valid  = 1'b1;
    out_ready = 1'b1;

    // 1: reset with in_valid high
    cyc();
    cyc();
    chk("rst_acc", acc_out, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_iready", in_ready, 1);
    chk("rst_state", dbg_state, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    cyc();
    chk("post_rst_count", count, 0);

    // 2: back-to-back beats, products 0,9,3,3
    exp_q.push_back(8'd15);
    send(2'd2, 2'd0);
    chk("b2b_acc1", acc_out, 0);
    chk("b2b_cnt1", count, 1);
    send(2'd3, 2'd3);
    chk("b2b_acc2", acc_out, 9);
    send(2'd1, 2'd3);
    chk("b2b_acc3", acc_out, 12);
    chk("b2b_cnt3", count, 3);
    send(2'd3, 2'd1);
    exp_v = exp_q.pop_front();
    chk("b2b_ovalid", out_valid, 1);
    chk("b2b_result", acc_out, exp_v);
    chk("b2b_count", count, 4);
    chk("b2b_ovf", overflow, 0);
    chk("b2b_iready", in_ready, 0);
    cyc();
    chk("b2b_idle_ovalid", out_valid, 0);
    chk("b2b_idle_iready", in_ready, 1);
    chk("b2b_idle_acc", acc_out, 0);

    // 3: backpressure, then a (2,2) beat starts a new sum
    out_ready = 1'b0;
    exp_q.push_back(8'd15);
    send(2'd2, 2'd0);
    send(2'd3, 2'd3);
    send(2'd1, 2'd3);
    send(2'd3, 2'd1);
    exp_v    = exp_q.pop_front();
    a        = 2'd2;
    b        = 2'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_acc", acc_out, exp_v);
      chk("bp_iready", in_ready, 0);
      chk("bp_count", count, 4);
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_release_iready", in_ready, 1);
    chk("bp_release_ovalid", out_valid, 0);
    cyc();
    in_valid = 1'b0;
    chk("bp_new_acc", acc_out, 4);
    chk("bp_new_count", count, 1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("bp_clear_count", count, 0);

    // 4: bubbles of two idle cycles between beats
    exp_q.push_back(8'd15);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: send(2'd2, 2'd0);
        1: send(2'd3, 2'd3);
        2: send(2'd1, 2'd3);
        default: send(2'd3, 2'd1);
      endcase
      chk("bub_count", count, i + 1);
      if (i < 3) begin
        cyc();
        cyc();
        chk("bub_hold", count, i + 1);
      end
    end
    chk("bub_ovalid", out_valid, 1);
    chk("bub_result", acc_out, exp_q.pop_front());
    cyc();

    // 5: wrap in the 4-bit instance, no wrap in the 8-bit one
    for (int i = 0; i < 4; i++) send(2'd3, 2'd3);
    chk("ovf4_ovalid", out_valid4, 1);
    chk("ovf4_acc", acc_out4, 4);
    chk("ovf4_flag", overflow4, 1);
    chk("ovf8_acc", acc_out, 36);
    chk("ovf8_flag", overflow, 0);
    cyc();
    chk("ovf4_idle_flag", overflow4, 0);
    for (int i = 0; i < 4; i++) send(2'd1, 2'd1);
    chk("ovf4_next_acc", acc_out4, 4);
    chk("ovf4_next_flag", overflow4, 0);
    cyc();

    // 6a: clear after two beats; beat in the clear cycle is dropped
    send(2'd2, 2'd3);
    send(2'd1, 2'd2);
    chk("clr_pre_acc", acc_out, 8);
    chk("clr_pre_count", count, 2);
    a        = 2'd3;
    b        = 2'd3;
    in_valid = 1'b1;
    clear    = 1'b1;
    cyc();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_acc", acc_out, 0);
    chk("clr_state", dbg_state, 0);
    exp_q.push_back(8'd13);
    out_ready = 1'b0;
    send(2'd1, 2'd1);
    send(2'd2, 2'd2);
    send(2'd3, 2'd2);
    send(2'd2, 2'd1);
    chk("clr_fresh_ovalid", out_valid, 1);
    chk("clr_fresh_result", acc_out, exp_q.pop_front());

    // 6b: reset while holding a result
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_done_ovalid", out_valid, 0);
    chk("rst_done_acc", acc_out, 0);
    chk("rst_done_iready", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vedic_mac_accumulator.md
Name: vedic_mac_accumulator

Overview:
- Multiply-accumulate stage built around the 2x2 vedic multiplier (instantiated internally, operand ports A/B, product port M).
- Accepts a stream of 2-bit operand pairs with a valid/ready handshake and forms each product.
- Sums NUM_TERMS products into one result and presents it on a valid/ready output.
- Used downstream of operand sources to build dot products from 2x2 multiplies.

Parameters:
- NUM_TERMS, 4, products summed per result; legal range 1..255.
- ACC_W, 8, accumulator/result width; must be >= 4.
- CNT_W, derived = clog2(NUM_TERMS+1), width of the count output; not overridden by users.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort of the current accumulation.
- A  input  2  operand A.
- B  input  2  operand B.
- in_valid  input  1  A/B valid this cycle.
- in_ready  output  1  block accepts A/B this cycle.
- acc_out  output  ACC_W  accumulated result.
- out_valid  output  1  acc_out holds a completed result.
- out_ready  input  1  consumer takes the result.
- overflow  output  1  sticky carry-out flag for the current/presented result.
- count  output  CNT_W  products accepted in the current result.

Behaviour:
- Reset: rst=1 at a clock edge forces the following values, and has priority over everything else.
  - state=IDLE, acc_out=0, count=0, overflow=0, out_valid=0, in_ready=1.
- Product: P = A*B from the internal 2x2 vedic multiplier, range 0..9. It is zero-extended to ACC_W before the add.
- Beat accepted when in_valid && in_ready at the clock edge.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On an accepted beat: acc<=P, count<=1, overflow<=0.
    - Goes to DONE if NUM_TERMS==1, else to ACCUM.
  - ACCUM: in_ready=1, out_valid=0.
    - On an accepted beat: acc<=acc+P (modulo 2^ACC_W), count<=count+1.
    - overflow<=overflow | carry-out of that add.
    - Goes to DONE when the accepted beat makes count==NUM_TERMS.
    - No accepted beat: all state held (bubbles allowed).
  - DONE: out_valid=1, in_ready=0; acc_out, count and overflow held stable.
    - When out_ready=1: next edge goes to IDLE with acc_out=0, count=0, overflow=0.
- Latency: out_valid rises on the edge after the last beat is accepted.
- There is a one-cycle bubble after each result: in_ready is 0 in DONE, so no beat can be accepted in the same cycle as the output handshake.
- in_valid is ignored while in DONE; the upstream source holds its data until in_ready=1.
- clear=1 (rst=0): next edge forces IDLE, acc_out=0, count=0, overflow=0, out_valid=0, regardless of state.
  - A beat presented in the same cycle as clear is discarded.
- Reset or clear while in DONE drops the pending result.
- acc_out is visible during accumulation as the running sum; it is only a qualified result when out_valid=1.
- Overflow behaviour: the sum wraps and the overflow flag stays set until the result is consumed, or until clear/rst.

Test Plan:
1. Reset: rst=1 for 2 cycles with in_valid=1 -> acc_out=0, count=0, overflow=0, out_valid=0, in_ready=1; no beat accepted.
2. Back-to-back beats, defaults: (A,B) = (2,0),(3,3),(1,3),(3,1), out_ready=1.
   - Products are 0,9,3,3.
   - out_valid=1 on the edge after beat 4, with acc_out=15, count=4, overflow=0.
   - Returns to IDLE one cycle later.
3. Backpressure: same stream with out_ready=0 for 5 cycles and in_valid held at 1.
   - acc_out stays 15 and in_ready stays 0; no beats are accepted.
   - After out_ready=1, in_ready=1 on the next cycle; the following (2,2) beat starts a new sum with acc_out=4.
4. Bubbles: the beats of scenario 2 with 2 idle cycles between each.
   - count steps 1,2,3,4 only on accepted beats.
   - Final acc_out=15.
5. Overflow: instance with ACC_W=4, four (3,3) beats.
   - acc_out=36 mod 16=4, overflow=1.
   - Next transaction (1,1)x4 gives acc_out=4, overflow=0.
6. Abort:
   - clear=1 after 2 accepted beats -> next edge count=0, acc_out=0, IDLE; a fresh 4-beat stream then gives the correct sum.
   - rst=1 while in DONE -> out_valid=0 next edge.
